// File: rtl/prog_sequencer.sv
// Program sequencer: produces the next program-memory address each cycle, with
// jumps, flag branches, call/return through a small return-address stack, halt/resume.
module prog_sequencer #(
    parameter int ADDR_W      = 5,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 0
) (
    input  logic                               clk,
    input  logic                               Reset,
    input  logic                               En,
    input  logic [2:0]                         Op,
    input  logic [ADDR_W-1:0]                  Target,
    input  logic                               CY,
    input  logic                               Z,
    input  logic                               Resume,
    output logic [ADDR_W-1:0]                  addr,
    output logic                               halted,
    output logic                               stack_err,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0]   SP_FULL   = SP_W'(STACK_DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_INIT = ADDR_W'(RESET_ADDR);

    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_JCY  = 3'd2;
    localparam logic [2:0] OP_JZ   = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [SP_W-1:0]   sp_reg, sp_next;
    logic [ADDR_W-1:0] addr_inc;
    logic [SP_W-1:0]   sp_dec;
    logic [IDX_W-1:0]  push_idx, pop_idx;
    logic              push;

    logic [ADDR_W-1:0] stack_mem [0:STACK_DEPTH-1];

    assign addr_inc = addr_reg + ADDR_W'(1);
    assign sp_dec   = sp_reg - SP_W'(1);
    // Indices are only used when sp is in range, so truncation is safe.
    assign push_idx = sp_reg[IDX_W-1:0];
    assign pop_idx  = sp_dec[IDX_W-1:0];

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        sp_next    = sp_reg;
        push       = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (En) begin
                    case (Op)
                        OP_JMP: addr_next = Target;
                        OP_JCY: addr_next = CY ? Target : addr_inc;
                        OP_JZ:  addr_next = Z ? Target : addr_inc;
                        OP_CALL: begin
                            if (sp_reg == SP_FULL) begin
                                state_next = ST_ERR;
                            end else begin
                                push      = 1'b1;
                                addr_next = Target;
                                sp_next   = sp_reg + SP_W'(1);
                            end
                        end
                        OP_RET: begin
                            if (sp_reg == '0) begin
                                state_next = ST_ERR;
                            end else begin
                                addr_next = stack_mem[pop_idx];
                                sp_next   = sp_dec;
                            end
                        end
                        OP_HALT: state_next = ST_HALT;
                        default: addr_next = addr_inc;
                    endcase
                end
            end
            ST_HALT: begin
                if (Resume) begin
                    addr_next  = addr_inc;
                    state_next = ST_RUN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_reg <= ST_RUN;
            addr_reg  <= ADDR_INIT;
            sp_reg    <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            sp_reg    <= sp_next;
        end
    end

    // Stack contents carry no reset; a push coinciding with Reset is dropped.
    always_ff @(posedge clk) begin
        if (push && !Reset) begin
            stack_mem[push_idx] <= addr_inc;
        end
    end

    assign addr      = addr_reg;
    assign sp        = sp_reg;
    assign halted    = (state_reg == ST_HALT);
    assign stack_err = (state_reg == ST_ERR);

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: a behavioural model predicts each cycle's result,
// queued at drive time and compared after the clock edge.
module tb_prog_sequencer;

    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int SPW   = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           Reset = 1'b0;
    logic           En = 1'b0;
    logic [2:0]     Op = 3'd0;
    logic [AW-1:0]  Target = '0;
    logic           CY = 1'b0;
    logic           Z = 1'b0;
    logic           Resume = 1'b0;
    logic [AW-1:0]  addr;
    logic           halted;
    logic           stack_err;
    logic [SPW-1:0] sp;

    prog_sequencer #(.ADDR_W(AW), .STACK_DEPTH(DEPTH), .RESET_ADDR(0)) dut (
        .clk(clk), .Reset(Reset), .En(En), .Op(Op), .Target(Target),
        .CY(CY), .Z(Z), .Resume(Resume),
        .addr(addr), .halted(halted), .stack_err(stack_err), .sp(sp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int s;
        int h;
        int e;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    // Reference model: 0 run, 1 halt, 2 error
    int m_addr  = 0;
    int m_state = 0;
    int m_stk[$];

    task automatic chk(input string tag, input int obs, input int want);
        n_total++;
        if (obs != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, want);
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic en,
                        input logic [2:0] op, input int tgt,
                        input logic cy, input logic z, input logic res);
        exp_t e;
        int   inc;
        @(negedge clk);
        Reset = rst; En = en; Op = op; Target = AW'(tgt);
        CY = cy; Z = z; Resume = res;
        inc = (m_addr + 1) % (1 << AW);
        if (rst) begin
            m_addr = 0; m_state = 0; m_stk.delete();
        end else if (m_state == 0 && en) begin
            case (op)
                3'd1: m_addr = tgt;
                3'd2: m_addr = cy ? tgt : inc;
                3'd3: m_addr = z ? tgt : inc;
                3'd4: if (m_stk.size() == DEPTH) m_state = 2;
                      else begin m_stk.push_back(inc); m_addr = tgt; end
                3'd5: if (m_stk.size() == 0) m_state = 2;
                      else m_addr = m_stk.pop_back();
                3'd6: m_state = 1;
                default: m_addr = inc;
            endcase
        end else if (m_state == 1 && res) begin
            m_addr = inc; m_state = 0;
        end
        e.a = m_addr; e.s = m_stk.size();
        e.h = (m_state == 1) ? 1 : 0; e.e = (m_state == 2) ? 1 : 0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".addr"}, int'(addr), e.a);
        chk({tag, ".sp"}, int'(sp), e.s);
        chk({tag, ".halted"}, int'(halted), e.h);
        chk({tag, ".err"}, int'(stack_err), e.e);
        $display("%-8s addr=%0d sp=%0d halted=%0b err=%0b", tag, addr, sp, halted, stack_err);
    endtask

    task automatic nxt(input string tag);
        step(tag, 0, 1, 3'd0, 0, 0, 0, 0);
    endtask

    task automatic rst(input string tag);
        step(tag, 1, 0, 3'd0, 0, 0, 0, 0);
    endtask

    initial begin
        rst("reset");
        for (int i = 0; i < 33; i++) nxt("next");
        step("rsv7", 0, 1, 3'd7, 17, 1, 1, 1);

        rst("reset");
        for (int i = 0; i < 3; i++) nxt("next");
        step("jmp", 0, 1, 3'd1, 20, 0, 0, 0);
        step("jcy_nt", 0, 1, 3'd2, 7, 0, 1, 0);
        step("jz_t", 0, 1, 3'd3, 9, 0, 1, 0);
        step("jz_nt", 0, 1, 3'd3, 2, 1, 0, 0);
        step("jcy_t", 0, 1, 3'd2, 14, 1, 0, 0);

        rst("reset");
        for (int i = 0; i < 5; i++) nxt("next");
        step("stall", 0, 0, 3'd4, 12, 0, 0, 0);
        step("call", 0, 1, 3'd4, 12, 0, 0, 0);
        step("ret", 0, 1, 3'd5, 0, 0, 0, 0);

        step("jmp31", 0, 1, 3'd1, 31, 0, 0, 0);
        step("call_wr", 0, 1, 3'd4, 3, 0, 0, 0);
        step("ret_wr", 0, 1, 3'd5, 0, 0, 0, 0);

        rst("reset");
        for (int i = 0; i < 4; i++) step("call_n", 0, 1, 3'd4, 4 * i + 2, 0, 0, 0);
        step("ret_top", 0, 1, 3'd5, 0, 0, 0, 0);
        step("call_r", 0, 1, 3'd4, 25, 0, 0, 0);
        step("call_ov", 0, 1, 3'd4, 30, 0, 0, 0);
        step("frz_res", 0, 1, 3'd0, 0, 0, 0, 1);
        step("frz_jmp", 0, 1, 3'd1, 3, 1, 1, 1);
        step("frz_ret", 0, 1, 3'd5, 0, 0, 0, 0);
        rst("reset");
        step("ret_un", 0, 1, 3'd5, 0, 0, 0, 0);
        step("frz_un", 0, 1, 3'd1, 6, 0, 0, 1);
        rst("reset");

        step("jmp10", 0, 1, 3'd1, 10, 0, 0, 0);
        step("halt", 0, 1, 3'd6, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("hold", 0, 1, 3'd1, 27, 1, 1, 0);
        step("resume", 0, 0, 3'd1, 27, 0, 0, 1);
        step("run_res", 0, 1, 3'd0, 0, 0, 0, 1);

        rst("reset");
        step("jmp8", 0, 1, 3'd1, 8, 0, 0, 0);
        step("call8a", 0, 1, 3'd4, 8, 0, 0, 0);
        step("call8b", 0, 1, 3'd4, 8, 0, 0, 0);
        step("rst_call", 1, 1, 3'd4, 15, 0, 0, 0);
        step("ret_clr", 0, 1, 3'd5, 0, 0, 0, 0);
        rst("reset");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Parametrised program sequencer that replaces the fixed 5-bit free-running program counter. Each cycle it produces the program-memory address that feeds the control-word decoder. It supports stall, absolute jump, conditional branch on carry or zero, subroutine call and return through an internal return-address stack, halt and resume, and sticky stack-error detection. The decoder output (Op, Target) is computed combinationally from `addr` and fed back into this block.

## Interface
Parameters:
- ADDR_W, 5: program address width; address space 2^ADDR_W words.
- STACK_DEPTH, 4: return-address stack entries (≥1).
- RESET_ADDR, 0: address loaded on Reset.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- En  in  1  advance enable; 0 = stall, all state held.
- Op  in  3  sequencing opcode of the current word: 0 NEXT, 1 JMP, 2 JCY, 3 JZ, 4 CALL, 5 RET, 6 HALT, 7 reserved (treated as NEXT).
- Target  in  ADDR_W  jump, branch or call destination.
- CY  in  1  carry flag, for JCY.
- Z  in  1  zero flag, for JZ.
- Resume  in  1  leave HALT.
- addr  out  ADDR_W  registered program address.
- halted  out  1  high in HALT state.
- stack_err  out  1  sticky overflow/underflow flag; high in ERR state.
- sp  out  clog2(STACK_DEPTH+1)  current stack occupancy.

## Operation
- States: RUN, HALT, ERR.
- Reset (dominates every other input): addr=RESET_ADDR, sp=0, halted=0, stack_err=0, state RUN. Stack contents are don't-care after Reset.
- RUN with En=0: addr, sp and state are held; Op is ignored.
- RUN with En=1, next addr by opcode:
  - NEXT/reserved: addr+1.
  - JMP: Target.
  - JCY: Target if CY=1, else addr+1.
  - JZ: Target if Z=1, else addr+1.
  - CALL: pushes addr+1, then loads Target; sp+1.
  - RET: pops the top entry into addr; sp−1.
  - HALT: addr held; go to HALT; halted=1.
- Arithmetic: addr+1 is modulo 2^ADDR_W. All-ones wraps to 0, and a CALL at all-ones pushes 0.
- CALL with sp==STACK_DEPTH: no push and addr held. Go to ERR with stack_err=1.
- RET with sp==0: addr held. Go to ERR with stack_err=1.
- HALT state:
  - Op and En are ignored.
  - Resume=1: addr+1, go to RUN, halted=0.
  - Resume=0: hold.
- ERR state: addr, sp and stack_err are frozen until Reset. Resume is ignored.
- Resume in RUN: ignored.
- CY and Z matter only for JCY and JZ respectively.

## Timing
- Op, Target, CY and Z are sampled at the posedge. The new addr is valid after that edge, giving 1 instruction per cycle with no bubbles on a taken branch.
- The path from addr through the external decoder to Op/Target and back to the next-addr mux is a single-cycle combinational loop. Total delay must fit within one period.
- halted, stack_err and sp are registered and update on the same edge as addr.
- Reset asserted mid-CALL/RET: the reset values take effect on that edge. The push or pop is discarded.
- Resume asserted on the same edge the HALT opcode is taken: it is ignored, because the state is still RUN. Resume must be seen in HALT, i.e. at least 1 cycle later.

## Test plan
- Reset, then NEXT with En=1 for 33 cycles (ADDR_W=5) → addr 0,1,…,31,0,1; halted=0, sp=0 throughout.
- At addr=3, JMP Target=20 → addr=20 next cycle. At addr=20, JCY Target=7 with CY=0 → addr=21. At addr=21, JZ Target=9 with Z=1 → addr=9.
- At addr=5, CALL Target=12 → addr=12, sp=1. Then RET → addr=6, sp=0. With En=0 during the CALL cycle → addr stays 5 and sp stays 0.
- STACK_DEPTH=4: five consecutive CALLs → after the 4th, sp=4. The 5th holds addr, sets stack_err=1, and Resume/Op changes leave everything frozen until Reset clears it. Separately, RET with sp=0 → stack_err=1.
- At addr=10, HALT → addr stays 10 and halted=1. Resume is held at 0 for 3 cycles → no change. Resume=1 → addr=11, halted=0.
- Reset asserted on a CALL cycle from addr=8, sp=2 → next cycle addr=RESET_ADDR, sp=0, stack_err=0, halted=0.
